// File: rtl/dlfloat_mac_seq.sv
// -----------------------------------------------------------------------------
// dlfloat_mac_seq
//   Sequencer that runs one dlfloat16 dot-product job on an external MAC
//   datapath. A job of i_len operand pairs clears the accumulator, streams
//   each accepted pair to the datapath with a one-cycle issue pulse, waits
//   MAC_LAT cycles for the last product to land, then presents the result
//   until the consumer takes it.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start, i_len         job request and pair count (sampled in IDLE)
//   o_busy                 high in every state except IDLE
//   i_in_valid, o_in_ready operand-pair handshake (ready only in ACCUM)
//   i_in_a, i_in_b         dlfloat16 operands
//   o_mac_a, o_mac_b       operands driven to the datapath
//   o_mac_issue            one-cycle pulse: o_mac_a/o_mac_b valid
//   o_mac_clear            one-cycle pulse: zero the datapath accumulator
//   i_mac_acc              accumulator value from the datapath
//   o_res_data, o_res_valid, i_res_ready   result handshake
// -----------------------------------------------------------------------------
module dlfloat_mac_seq #(
    parameter int MAC_LAT = 3,
    parameter int LEN_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [15:0]      i_in_a,
    input  logic [15:0]      i_in_b,
    output logic [15:0]      o_mac_a,
    output logic [15:0]      o_mac_b,
    output logic             o_mac_issue,
    output logic             o_mac_clear,
    input  logic [15:0]      i_mac_acc,
    output logic [15:0]      o_res_data,
    output logic             o_res_valid,
    input  logic             i_res_ready
);

    // Drain counter must hold the value MAC_LAT.
    localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_remain;
    logic [LEN_W-1:0] w_remain_nxt;
    logic [DW-1:0]    r_drain;
    logic [DW-1:0]    w_drain_nxt;
    logic [15:0]      r_mac_a;
    logic [15:0]      w_mac_a_nxt;
    logic [15:0]      r_mac_b;
    logic [15:0]      w_mac_b_nxt;
    logic [15:0]      r_res_data;
    logic [15:0]      w_res_data_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic             r_mac_issue;
    logic             w_mac_issue_nxt;
    logic             r_mac_clear;
    logic             w_mac_clear_nxt;
    logic             r_res_valid;
    logic             w_res_valid_nxt;
    logic             w_hs;

    // The remaining-count guard keeps the counter from ever underflowing.
    assign w_hs = i_in_valid & r_in_ready & (r_remain != {LEN_W{1'b0}});

    // Next-state and next-output logic; outputs are derived from the next state
    // so that every output comes straight from a register.
    always_comb begin
        w_state_nxt     = r_state;
        w_remain_nxt    = r_remain;
        w_drain_nxt     = r_drain;
        w_mac_a_nxt     = r_mac_a;
        w_mac_b_nxt     = r_mac_b;
        w_res_data_nxt  = r_res_data;
        w_mac_issue_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_remain_nxt = i_len;
                    if (i_len == {LEN_W{1'b0}}) begin
                        w_res_data_nxt = 16'h0000;
                        w_state_nxt    = S_DONE;
                    end else begin
                        w_state_nxt    = S_CLEAR;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                if (w_hs) begin
                    w_mac_a_nxt     = i_in_a;
                    w_mac_b_nxt     = i_in_b;
                    w_mac_issue_nxt = 1'b1;
                    w_remain_nxt    = r_remain - LEN_W'(1);
                    if (r_remain == LEN_W'(1)) begin
                        // First DRAIN cycle is the final issue cycle, so the
                        // capture happens MAC_LAT cycles later.
                        w_drain_nxt = DW'(MAC_LAT);
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end else begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_DRAIN: begin
                if (r_drain == {DW{1'b0}}) begin
                    w_res_data_nxt = i_mac_acc;
                    w_state_nxt    = S_DONE;
                end else begin
                    w_drain_nxt    = r_drain - DW'(1);
                end
            end
            S_DONE: begin
                if (i_res_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_in_ready_nxt  = (w_state_nxt == S_ACCUM);
        w_mac_clear_nxt = (w_state_nxt == S_CLEAR);
        w_res_valid_nxt = (w_state_nxt == S_DONE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_remain    <= {LEN_W{1'b0}};
            r_drain     <= {DW{1'b0}};
            r_mac_a     <= 16'h0000;
            r_mac_b     <= 16'h0000;
            r_res_data  <= 16'h0000;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_mac_issue <= 1'b0;
            r_mac_clear <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remain    <= w_remain_nxt;
            r_drain     <= w_drain_nxt;
            r_mac_a     <= w_mac_a_nxt;
            r_mac_b     <= w_mac_b_nxt;
            r_res_data  <= w_res_data_nxt;
            r_busy      <= w_busy_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_mac_issue <= w_mac_issue_nxt;
            r_mac_clear <= w_mac_clear_nxt;
            r_res_valid <= w_res_valid_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_in_ready  = r_in_ready;
    assign o_mac_a     = r_mac_a;
    assign o_mac_b     = r_mac_b;
    assign o_mac_issue = r_mac_issue;
    assign o_mac_clear = r_mac_clear;
    assign o_res_data  = r_res_data;
    assign o_res_valid = r_res_valid;

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_dlfloat_mac_seq
//   Directed bench for dlfloat_mac_seq with a behavioural dlfloat16 MAC of
//   latency MAC_LAT. Table-driven jobs plus hand-written reset and long-job
//   sequences.
// -----------------------------------------------------------------------------
module tb_dlfloat_mac_seq;

    localparam int MAC_LAT = 3;
    localparam int LEN_W   = 8;
    localparam int PD      = MAC_LAT - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             mac_issue;
    logic             mac_clear;
    logic [15:0]      mac_acc;
    logic [15:0]      res_data;
    logic             res_valid;
    logic             res_ready;

    dlfloat_mac_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_len       (len),
        .o_busy      (busy),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .o_mac_a     (mac_a),
        .o_mac_b     (mac_b),
        .o_mac_issue (mac_issue),
        .o_mac_clear (mac_clear),
        .i_mac_acc   (mac_acc),
        .o_res_data  (res_data),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // dlfloat16 <-> real helpers for the behavioural MAC
    function automatic real dec(input logic [15:0] x);
        real m;
        int  e;
        if (x[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(x[8:0]) / 512.0;
        e = int'(x[14:9]) - 31;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] enc(input real r);
        real        m;
        int         e;
        logic       s;
        logic [5:0] ex;
        logic [8:0] man;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        ex  = 6'(e + 31);
        man = 9'($rtoi((m - 1.0) * 512.0));
        return {s, ex, man};
    endfunction

    // Behavioural MAC: a product issued in cycle T is visible on mac_acc in T+MAC_LAT.
    real acc_q = 0.0;
    bit  pv  [PD];
    real pvv [PD];
    always @(posedge clk) begin
        if (rst || mac_clear) acc_q <= 0.0;
        else if (pv[PD-1])    acc_q <= acc_q + pvv[PD-1];
        else                  acc_q <= acc_q;
        pv[0]  <= mac_issue && !rst;
        pvv[0] <= dec(mac_a) * dec(mac_b);
        for (int i = 1; i < PD; i++) begin
            pv[i]  <= pv[i-1] && !rst;
            pvv[i] <= pvv[i-1];
        end
    end
    assign mac_acc = enc(acc_q);

    // Event monitor: cycle counter, pulse counts, issue-follows-handshake check.
    int cyc        = 0;
    int n_issue    = 0;
    int n_clear    = 0;
    int issue_err  = 0;
    int last_issue = 0;
    bit hs_d       = 1'b0;
    bit mon_en     = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_issue) begin
            n_issue    <= n_issue + 1;
            last_issue <= cyc;
        end
        if (mac_clear) n_clear <= n_clear + 1;
        if (mon_en && (mac_issue !== hs_d)) issue_err <= issue_err + 1;
        hs_d <= in_valid && in_ready && !rst;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "/busy"},      32'(busy),      32'd0);
        chk({nm, "/in_ready"},  32'(in_ready),  32'd0);
        chk({nm, "/mac_issue"}, 32'(mac_issue), 32'd0);
        chk({nm, "/mac_clear"}, 32'(mac_clear), 32'd0);
        chk({nm, "/res_valid"}, 32'(res_valid), 32'd0);
        chk({nm, "/res_data"},  32'(res_data),  32'd0);
        chk({nm, "/mac_a"},     32'(mac_a),     32'd0);
        chk({nm, "/mac_b"},     32'(mac_b),     32'd0);
    endtask

    // One job record; a/b hold up to four pairs, index 0 first.
    // noise=1 drives start high and res_ready high while the job runs.
    typedef struct packed {
        logic [7:0]       len;
        logic [3:0]       gap;
        logic             noise;
        logic [3:0]       hold;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [15:0]      exp_res;
    } vec_t;

    task automatic run_job(input vec_t v, input string nm);
        int          base_i;
        int          base_c;
        int          base_e;
        int          stab;
        logic [15:0] held;
        base_i = n_issue;
        base_c = n_clear;
        base_e = issue_err;
        stab   = 0;
        start = 1'b1; len = v.len; res_ready = v.noise;
        @(negedge clk);
        start = v.noise; len = 8'd5;
        for (int p = 0; p < int'(v.len); p++) begin
            in_valid = 1'b1; in_a = v.a[p]; in_b = v.b[p];
            for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
            chk({nm, "/in_ready"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            if (p < int'(v.len) - 1) begin
                for (int g = 0; g < int'(v.gap); g++) @(negedge clk);
            end
        end
        start = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 60 && !res_valid; k++) @(negedge clk);
        chk({nm, "/res_valid"}, 32'(res_valid), 32'd1);
        chk({nm, "/res_data"},  32'(res_data),  32'(v.exp_res));
        if (v.len != 8'd0) chk({nm, "/latency"}, 32'(cyc - last_issue), 32'(MAC_LAT + 1));
        if (v.hold != 4'd0) begin
            held = v.exp_res;
            for (int k = 0; k < int'(v.hold); k++) begin
                start = k[0]; len = 8'd3;
                @(negedge clk);
                if (!res_valid || res_data !== held || !busy) stab++;
            end
            start = 1'b0;
            chk({nm, "/done_stable"}, 32'(stab), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk({nm, "/valid_dropped"}, 32'(res_valid), 32'd0);
        chk({nm, "/idle"},          32'(busy),      32'd0);
        res_ready = 1'b0;
        chk({nm, "/clears"},    32'(n_clear - base_c),   (v.len != 8'd0) ? 32'd1 : 32'd0);
        chk({nm, "/issues"},    32'(n_issue - base_i),   32'(v.len));
        chk({nm, "/issue_lag"}, 32'(issue_err - base_e), 32'd0);
    endtask

    vec_t vecs [6];
    vec_t one;
    int   bcnt;
    int   base_i;

    initial begin
        //            len    gap   noise hold  a{3,2,1,0}                              b{3,2,1,0}                              result
        vecs[0] = {8'd2, 4'd0, 1'b0, 4'd0, {16'h0000, 16'h0000, 16'h4000, 16'h3E00}, {16'h0000, 16'h0000, 16'h3E00, 16'h3E00}, 16'h4100}; // 1+2=3
        vecs[1] = {8'd3, 4'd5, 1'b0, 4'd0, {16'h0000, 16'h3E00, 16'h3E00, 16'h4000}, {16'h0000, 16'h3E00, 16'h4000, 16'h4000}, 16'h4380}; // 4+2+1=7
        vecs[2] = {8'd0, 4'd0, 1'b0, 4'd0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000}; // empty job
        vecs[3] = {8'd2, 4'd1, 1'b1, 4'd0, {16'h0000, 16'h0000, 16'h4000, 16'hBE00}, {16'h0000, 16'h0000, 16'h4000, 16'h4000}, 16'h4000}; // -2+4=2
        vecs[4] = {8'd4, 4'd1, 1'b0, 4'd0, {16'h3F00, 16'h3F00, 16'h3F00, 16'h3F00}, {16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00}, 16'h4300}; // 4*1.5=6
        vecs[5] = {8'd1, 4'd0, 1'b0, 4'd10, {16'h0000, 16'h0000, 16'h0000, 16'h4000}, {16'h0000, 16'h0000, 16'h0000, 16'h3F00}, 16'h4100}; // 2*1.5=3, hold in DONE

        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
        in_a = 16'h0000; in_b = 16'h0000; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Reset one cycle after the 2nd handshake of a len=4 job.
        base_i = n_issue;
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_a = 16'h4000; in_b = 16'h4000;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        chk("rstjob/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);                 // 2nd handshake edge has passed
        rst = 1'b1; start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        chk_reset_state("midjob_reset");
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (8) @(negedge clk);
        chk("midjob_reset/no_more_issue", 32'(n_issue - base_i), 32'd2);
        chk("midjob_reset/still_idle",    32'(busy),             32'd0);
        one = {8'd1, 4'd0, 1'b0, 4'd0, {16'h0000, 16'h0000, 16'h0000, 16'h3E00}, {16'h0000, 16'h0000, 16'h0000, 16'h3E00}, 16'h3E00};
        run_job(one, "after_reset");

        // Longest job with continuous in_valid: 255 * (1*1) = 255.
        base_i = n_issue;
        bcnt = 0;
        start = 1'b1; len = 8'd255;
        in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3E00;
        @(negedge clk);
        start = 1'b0;
        if (busy) bcnt++;
        for (int k = 0; k < 400 && !res_valid; k++) begin
            @(negedge clk);
            if (busy && !res_valid) bcnt++;
        end
        in_valid = 1'b0;
        chk("len255/res_valid",   32'(res_valid),        32'd1);
        chk("len255/res_data",    32'(res_data),         32'h4DFC);
        chk("len255/issues",      32'(n_issue - base_i), 32'd255);
        chk("len255/busy_cycles", 32'(bcnt),             32'(1 + 255 + MAC_LAT + 1));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("len255/idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
